// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: glyph table used by both the scan driver
// and the capture decoder, plus small helpers.
package seven_seg_pkg;

   localparam int NUM_DIGITS = 8;

   // Active-high segments, bit0 = a ... bit6 = g; entry k is the glyph for nibble k.
   localparam logic [15:0][6:0] SEG_GLYPH = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Index of the set bit of a one-hot digit enable; only meaningful when exactly one bit is set.
   function automatic logic [2:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational reverse lookup of an active-high segment pattern into a hex nibble.
module seg_glyph_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] nibble_o,
   output logic       hit_o
);

   always_comb begin
      nibble_o = '0;
      hit_o    = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (seg_i == SEG_GLYPH[k]) begin
            hit_o    = 1'b1;
            nibble_o = 4'(k);
         end
      end
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a multiplexed active-low seven-segment scan bus, debounces each scan
// step, decodes glyphs and reassembles complete 8-digit frames.
module seven_segment_capture
   import seven_seg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  cat,
   input  logic [7:0]  an,
   output logic [31:0] val,
   output logic        val_valid,
   output logic [7:0]  digit_mask,
   output logic        decode_err
);

   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      STAB_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0]      STAB_ARM = 8'(STABLE_CYCLES - 1);

   // Bus layout {an, cat}; all ones means every digit and segment dark.
   logic [14:0]     meta_q, syn_q, prv_q;
   logic [7:0]      stab_q, stab_d;
   logic            armed_q, armed_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [31:0]     shadow_q, shadow_d;
   logic [7:0]      mask_q, mask_d;
   logic [31:0]     val_q, val_d;
   logic            val_valid_q, val_valid_d;
   logic            decode_err_q, decode_err_d;

   logic [6:0] seg;
   logic [7:0] en;
   logic [2:0] idx;
   logic       multi;
   logic       take;
   logic       hit_frame;
   logic [3:0] nibble;
   logic       glyph_hit;

   assign seg   = ~syn_q[6:0];
   assign en    = ~syn_q[14:7];
   assign idx   = onehot_idx(en);
   assign multi = (en & (en - 8'd1)) != 8'd0;
   assign take  = (syn_q == prv_q) && armed_q && (stab_q == STAB_ARM);

   seg_glyph_decode u_decode (
      .seg_i    (seg),
      .nibble_o (nibble),
      .hit_o    (glyph_hit)
   );

   always_comb begin
      stab_d       = stab_q;
      armed_d      = armed_q;
      to_d         = (to_q == TO_LAST) ? to_q : to_q + TO_W'(1);
      shadow_d     = shadow_q;
      mask_d       = mask_q;
      val_d        = val_q;
      val_valid_d  = 1'b0;
      decode_err_d = 1'b0;
      hit_frame    = 1'b0;

      if (syn_q != prv_q) begin
         stab_d  = '0;
         armed_d = 1'b1;
      end else begin
         if (stab_q != STAB_MAX) stab_d = stab_q + 8'd1;
         if (take) armed_d = 1'b0;
      end

      // Blank steps fall through untouched: no error and no timeout restart.
      if (take && (en != 8'd0)) begin
         if (multi || !glyph_hit) begin
            decode_err_d = 1'b1;
         end else begin
            hit_frame                    = 1'b1;
            shadow_d[{idx, 2'b00} +: 4]  = nibble;
            mask_d                       = mask_q | (8'd1 << idx);
            to_d                         = '0;
            if (&mask_d) begin
               val_d       = shadow_d;
               val_valid_d = 1'b1;
               mask_d      = '0;
            end
         end
      end

      // A hit on the same edge as the timeout keeps the frame alive.
      if (!hit_frame && (to_q == TO_LAST) && (mask_q != 8'd0)) begin
         mask_d = '0;
         to_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q       <= '1;
         syn_q        <= '1;
         prv_q        <= '1;
         stab_q       <= '0;
         armed_q      <= 1'b0;
         to_q         <= '0;
         shadow_q     <= '0;
         mask_q       <= '0;
         val_q        <= '0;
         val_valid_q  <= 1'b0;
         decode_err_q <= 1'b0;
      end else begin
         meta_q       <= {an, cat};
         syn_q        <= meta_q;
         prv_q        <= syn_q;
         stab_q       <= stab_d;
         armed_q      <= armed_d;
         to_q         <= to_d;
         shadow_q     <= shadow_d;
         mask_q       <= mask_d;
         val_q        <= val_d;
         val_valid_q  <= val_valid_d;
         decode_err_q <= decode_err_d;
      end
   end

   assign val        = val_q;
   assign val_valid  = val_valid_q;
   assign digit_mask = mask_q;
   assign decode_err = decode_err_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed and randomized scan sequences checked against a frame-level model of
// the capture block.
module tb_seven_segment_capture;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 64;
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  cat = 7'h7F;
   logic [7:0]  an  = 8'hFF;
   logic [31:0] val;
   logic        val_valid;
   logic [7:0]  digit_mask;
   logic        decode_err;

   seven_segment_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .cat        (cat),
      .an         (an),
      .val        (val),
      .val_valid  (val_valid),
      .digit_mask (digit_mask),
      .decode_err (decode_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int vv_seen  = 0;
   int err_seen = 0;
   int exp_vv   = 0;
   int exp_err  = 0;

   // Frame-level model state
   logic [31:0] m_val    = '0;
   logic [31:0] m_shadow = '0;
   logic [7:0]  m_mask   = '0;
   logic [7:0]  cur_an   = 8'hFF;
   logic [6:0]  cur_cat  = 7'h7F;
   logic [31:0] prev_val = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Pulse counting plus invariants that must hold every cycle.
   always @(negedge clk) begin
      if (val_valid === 1'b1) vv_seen++;
      if (decode_err === 1'b1) err_seen++;
      if (!rst) begin
         n_checks++;
         assert (!(val_valid === 1'b1 && decode_err === 1'b1)) n_pass++;
         else $error("FAIL pulse_overlap: observed vv=%b err=%b expected not both", val_valid, decode_err);
         n_checks++;
         assert (val === prev_val || val_valid === 1'b1) n_pass++;
         else $error("FAIL val_hold: observed 0x%0h expected 0x%0h", val, prev_val);
      end
      prev_val = val;
   end

   function automatic logic [7:0] dig_an(input int i);
      logic [7:0] one;
      one = 8'd1 << i;
      return ~one;
   endfunction

   function automatic logic [6:0] dig_cat(input logic [3:0] nib);
      return ~GLYPH[nib];
   endfunction

   function automatic bit in_table(input logic [6:0] s);
      bit f;
      f = 0;
      for (int k = 0; k < 16; k++) if (GLYPH[k] == s) f = 1;
      return f;
   endfunction

   // One accepted sample, evaluated straight from the decoding rules.
   task automatic model_sample(input logic [7:0] a, input logic [6:0] c);
      logic [7:0] e;
      logic [6:0] s;
      logic [3:0] nib;
      bit         found;
      int         di;
      e = ~a;
      s = ~c;
      found = 0;
      nib = '0;
      di = 0;
      if (e == 8'd0) return;
      if ($countones(e) != 1) begin
         exp_err++;
         return;
      end
      for (int i = 0; i < 8; i++) if (e[i]) di = i;
      for (int k = 0; k < 16; k++) begin
         if (GLYPH[k] == s) begin
            found = 1;
            nib = k[3:0];
         end
      end
      if (!found) begin
         exp_err++;
         return;
      end
      m_shadow[4*di +: 4] = nib;
      m_mask[di] = 1'b1;
      if (m_mask == 8'hFF) begin
         m_val  = m_shadow;
         m_mask = '0;
         exp_vv++;
      end
   endtask

   // Drive the pins for the given number of clocks; a new window of at least
   // STABLE clocks yields exactly one sample.
   task automatic drive(input logic [7:0] a, input logic [6:0] c);
      if ({a, c} != {cur_an, cur_cat}) model_sample(a, c);
      cur_an  = a;
      cur_cat = c;
      an      = a;
      cat     = c;
   endtask

   task automatic step(input logic [7:0] a, input logic [6:0] c, input int hold);
      if (hold >= STABLE) drive(a, c);
      else begin
         cur_an  = a;
         cur_cat = c;
         an      = a;
         cat     = c;
      end
      repeat (hold) @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_mask"}, {24'd0, digit_mask}, {24'd0, m_mask});
      chk({tag, "_val"}, val, m_val);
      chk({tag, "_vv"}, vv_seen, exp_vv);
      chk({tag, "_err"}, err_seen, exp_err);
   endtask

   task automatic send_value(input logic [31:0] v, input int hold);
      for (int i = 0; i < 8; i++) step(dig_an(i), dig_cat(v[4*i +: 4]), hold);
   endtask

   initial begin
      logic [31:0] rv;
      int          perm [8];
      int          j, t, b1, b2;
      logic [6:0]  bad;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_val", val, 32'h0);
      chk("rst_vv", {31'd0, val_valid}, 32'd0);
      chk("rst_err", {31'd0, decode_err}, 32'd0);
      chk("rst_mask", {24'd0, digit_mask}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal frame with exact completion latency
      for (int i = 0; i < 7; i++) step(dig_an(i), dig_cat(4'(32'h1234ABCD >> (4*i))), 20);
      chk("nom_mask7", {24'd0, digit_mask}, 32'h7F);
      drive(dig_an(7), dig_cat(4'h1));
      repeat (6) @(negedge clk);
      chk("nom_lat_early", {31'd0, val_valid}, 32'd0);
      @(negedge clk);
      chk("nom_lat_vv", {31'd0, val_valid}, 32'd1);
      chk("nom_lat_val", val, 32'h1234ABCD);
      repeat (13) @(negedge clk);
      check_state("nominal");

      // Glitch inside a stable digit is filtered
      for (int i = 0; i < 4; i++) step(dig_an(i), dig_cat(4'(32'h89ABCDEF >> (4*i))), 10);
      step(dig_an(3), 7'h7F, 2);
      step(dig_an(3), dig_cat(4'hC), 10);
      check_state("glitch_mid");
      for (int i = 4; i < 8; i++) step(dig_an(i), dig_cat(4'(32'h89ABCDEF >> (4*i))), 10);
      check_state("glitch_end");
      chk("glitch_val", val, 32'h89ABCDEF);

      // Illegal samples
      step(8'b1111_1100, dig_cat(4'h5), 10);
      check_state("multi_en");
      step(dig_an(5), 7'h7F, 10);
      check_state("blank_glyph");
      chk("blank_glyph_m5", {31'd0, digit_mask[5]}, 32'd0);
      step(8'hFF, 7'h7F, 10);

      // Timeout of a partial frame
      for (int i = 0; i < 3; i++) step(dig_an(i), dig_cat(4'h0), 20);
      drive(dig_an(3), dig_cat(4'h0));
      repeat (10) @(negedge clk);
      drive(8'hFF, 7'h7F);
      repeat (60) @(negedge clk);
      chk("to_before", {24'd0, digit_mask}, 32'h0F);
      @(negedge clk);
      chk("to_cleared", {24'd0, digit_mask}, 32'h00);
      m_mask = '0;
      repeat (40) @(negedge clk);
      check_state("timeout");

      // Asynchronous reset mid-frame
      for (int i = 0; i < 5; i++) step(dig_an(i), dig_cat(4'h2), 12);
      step(8'hFF, 7'h7F, 10);
      chk("pre_rst_mask", {24'd0, digit_mask}, 32'h1F);
      #2 rst = 1'b1;
      #1;
      chk("arst_val", val, 32'h0);
      chk("arst_mask", {24'd0, digit_mask}, 32'h0);
      chk("arst_vv", {31'd0, val_valid}, 32'd0);
      chk("arst_err", {31'd0, decode_err}, 32'd0);
      #4 rst = 1'b0;
      m_val = '0;
      m_mask = '0;
      m_shadow = '0;
      prev_val = '0;
      @(negedge clk);
      send_value(32'hDEADBEEF, 12);
      check_state("after_rst");
      chk("deadbeef", val, 32'hDEADBEEF);

      // Overwrite and reverse order
      t = exp_vv;
      step(dig_an(2), dig_cat(4'h7), 10);
      step(dig_an(2), dig_cat(4'h9), 10);
      for (int i = 7; i >= 0; i--) begin
         if (i != 2) step(dig_an(i), dig_cat(4'(32'h76543921 >> (4*i))), 10);
      end
      check_state("overwrite");
      chk("ovr_single", vv_seen, t + 1);
      chk("ovr_nib", {28'd0, val[11:8]}, 32'h9);
      chk("ovr_val", val, 32'h76543921);

      // Randomized frames with interleaved illegal or blank steps
      for (int f = 0; f < 8; f++) begin
         rv = $urandom;
         for (int i = 0; i < 8; i++) perm[i] = i;
         for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
         end
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 9) < 3) begin
               case ($urandom_range(0, 2))
                  0: step(8'hFF, 7'($urandom_range(0, 127)), $urandom_range(8, 14));
                  1: begin
                     b1 = $urandom_range(0, 7);
                     b2 = (b1 + $urandom_range(1, 7)) % 8;
                     step(dig_an(b1) & dig_an(b2), dig_cat(4'($urandom_range(0, 15))), $urandom_range(8, 14));
                  end
                  default: begin
                     bad = 7'($urandom_range(0, 127));
                     while (in_table(bad)) bad = 7'($urandom_range(0, 127));
                     step(dig_an($urandom_range(0, 7)), ~bad, $urandom_range(8, 14));
                  end
               endcase
               check_state("rnd_inject");
            end
            step(dig_an(perm[i]), dig_cat(rv[4*perm[i] +: 4]), $urandom_range(8, 14));
            check_state("rnd_digit");
         end
         chk("rnd_frame_val", val, rv);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
